// File: rtl/hamming_rx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_rx_pkg
//  Purpose  : Shared types and constants for the Hamming(7,4) receive
//             sequencer: FSM state encoding, codeword/nibble widths, timer
//             width and the default decoder timeout.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hamming_rx_pkg;

  // Hamming(7,4): 7-bit codeword in, 4-bit data nibble out.
  localparam int CW_W            = 7;
  localparam int NIB_W           = 4;
  localparam int BYTE_W          = 2 * NIB_W;
  localparam int SYN_W           = 3;

  // Decoder response timeout; the timer is wide enough for limits 1..255.
  localparam int DEFAULT_TIMEOUT = 15;
  localparam int TMR_W           = 8;

  // Encodings are visible on state_dbg, so they are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // The first decoded nibble becomes the low half of the byte.
  function automatic logic [BYTE_W-1:0] pack_byte(
    input logic [NIB_W-1:0] hi,
    input logic [NIB_W-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_rx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_rx_sequencer_if
//  Purpose  : Bundles the UART-side, decoder-side, byte-output and status
//             signals of the receive sequencer.
//  Modports : master - the sequencer (drives dec_*, byte_*, status)
//             slave  - the surrounding system (UART, decoder, consumer)
//  Signals  : uart_valid/uart_data      codeword from the UART receiver
//             dec_ena/dec_in            request to the Hamming decoder
//             dec_valid/dec_data/
//             dec_syndrome              decoder response
//             byte_data/byte_valid/
//             byte_ready                assembled byte handshake
//             clr_flags                 clears sticky status
//             err_count/overrun/
//             timeout/state_dbg         status readout
//  Revision : 1.0 - initial release
// ============================================================================
interface hamming_rx_sequencer_if
  import hamming_rx_pkg::*;
#(
  parameter int ERR_CNT_W = 8
);

  logic                  uart_valid;
  logic [CW_W-1:0]       uart_data;

  logic                  dec_ena;
  logic [CW_W-1:0]       dec_in;
  logic                  dec_valid;
  logic [NIB_W-1:0]      dec_data;
  logic [SYN_W-1:0]      dec_syndrome;

  logic [BYTE_W-1:0]     byte_data;
  logic                  byte_valid;
  logic                  byte_ready;

  logic                  clr_flags;
  logic [ERR_CNT_W-1:0]  err_count;
  logic                  overrun;
  logic                  timeout;
  logic [1:0]            state_dbg;

  modport master (
    input  uart_valid, uart_data,
    output dec_ena, dec_in,
    input  dec_valid, dec_data, dec_syndrome,
    output byte_data, byte_valid,
    input  byte_ready,
    input  clr_flags,
    output err_count, overrun, timeout, state_dbg
  );

  modport slave (
    output uart_valid, uart_data,
    input  dec_ena, dec_in,
    output dec_valid, dec_data, dec_syndrome,
    input  byte_data, byte_valid,
    output byte_ready,
    output clr_flags,
    input  err_count, overrun, timeout, state_dbg
  );

endinterface
`default_nettype wire

// File: rtl/hamming_rx_sequencer_timer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_timeout_timer
//  Purpose  : Cycle counter for the decoder-response wait. Counts while
//             enabled and flags the cycle in which the count reaches the
//             limit, so the owner leaves after exactly 'limit' wait cycles.
//  Ports    : clk      clock
//             rst      asynchronous active-high reset
//             clear    restart the count at zero (priority over enable)
//             enable   count this cycle
//             limit    number of enabled cycles before expiry (>= 1)
//             expired  high during the last allowed enabled cycle
//  Revision : 1.0 - initial release
// ============================================================================
module rx_timeout_timer #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             enable,
  input  wire logic [CNT_W-1:0] limit,
  output logic                  expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // The count equals the number of enabled cycles already completed, so the
  // final allowed cycle is the one where it reads limit-1. Raising expiry
  // there lets the owner act on the same edge the count would hit the limit.
  assign expired = enable && (r_count == (limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/hamming_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_rx_sequencer
//  Purpose  : Sequences codewords from the UART receiver into the Hamming(7,4)
//             decoder, collects two decoded nibbles (low first) into a byte
//             and offers it on a valid/ready handshake. Keeps a saturating
//             corrected-error count and sticky overrun/timeout flags.
//  Ports    : clk   clock
//             rst   asynchronous active-high reset
//             bus   hamming_rx_sequencer_if.master (all data/status signals)
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_rx_sequencer
  import hamming_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int ERR_CNT_W      = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  hamming_rx_sequencer_if.master   bus
);

  localparam logic [TMR_W-1:0]     c_timeout_limit = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [ERR_CNT_W-1:0] c_err_max       = {ERR_CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic                 r_dec_ena;
  logic [CW_W-1:0]      r_dec_in;
  logic [NIB_W-1:0]     r_low_nib;
  logic                 r_nib_idx;
  logic [BYTE_W-1:0]    r_byte_data;
  logic                 r_byte_valid;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_overrun;
  logic                 r_timeout;

  logic                 w_tmr_clear;
  logic                 w_tmr_enable;
  logic                 w_tmr_expired;
  logic                 w_dec_resp;
  logic                 w_corrected;
  logic                 w_dropped;

  // --------------------------------------------------------------------------
  // Decoder response timer: restarted in ISSUE, runs only while in WAIT.
  // --------------------------------------------------------------------------
  assign w_tmr_clear  = (r_state == ST_ISSUE);
  assign w_tmr_enable = (r_state == ST_WAIT);

  rx_timeout_timer #(
    .CNT_W   (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_enable),
    .limit   (c_timeout_limit),
    .expired (w_tmr_expired)
  );

  // Decoder responses only count while a request is outstanding.
  assign w_dec_resp  = (r_state == ST_WAIT) && bus.dec_valid;
  assign w_corrected = w_dec_resp && (bus.dec_syndrome != '0);
  // Any codeword arriving outside IDLE is lost.
  assign w_dropped   = bus.uart_valid && (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered outputs and status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dec_ena    <= 1'b0;
      r_dec_in     <= '0;
      r_low_nib    <= '0;
      r_nib_idx    <= 1'b0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_err_count  <= '0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      // dec_ena is a single-cycle strobe: only IDLE->ISSUE raises it.
      r_dec_ena <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.uart_valid) begin
            r_dec_in  <= bus.uart_data;
            r_dec_ena <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A response in the expiry cycle still wins over the timeout.
          if (bus.dec_valid) begin
            if (!r_nib_idx) begin
              r_low_nib <= bus.dec_data;
              r_nib_idx <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_byte_data  <= pack_byte(bus.dec_data, r_low_nib);
              r_byte_valid <= 1'b1;
              r_nib_idx    <= 1'b0;
              r_state      <= ST_OUT;
            end
          end else if (w_tmr_expired) begin
            // A half-built byte cannot be trusted once a codeword is lost.
            r_timeout <= 1'b1;
            r_nib_idx <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        ST_OUT: begin
          if (bus.byte_ready) begin
            r_byte_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_dropped) begin
        r_overrun <= 1'b1;
      end

      if (w_corrected && (r_err_count != c_err_max)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end

      // Placed last so a clear overrides a same-cycle set or increment.
      if (bus.clr_flags) begin
        r_overrun   <= 1'b0;
        r_timeout   <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.dec_ena    = r_dec_ena;
  assign bus.dec_in     = r_dec_in;
  assign bus.byte_data  = r_byte_data;
  assign bus.byte_valid = r_byte_valid;
  assign bus.err_count  = r_err_count;
  assign bus.overrun    = r_overrun;
  assign bus.timeout    = r_timeout;
  assign bus.state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hamming_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hamming_rx_sequencer
//  Purpose  : Self-checking bench for hamming_rx_sequencer. A small decoder
//             model answers each dec_ena after a programmable latency with a
//             chosen nibble and syndrome. Inputs change on the falling edge;
//             outputs are sampled on the falling edge as well.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_rx_sequencer;
  import hamming_rx_pkg::*;

  localparam int TO = 15;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming_rx_sequencer_if #(.ERR_CNT_W(EW)) bus ();

  hamming_rx_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .ERR_CNT_W      (EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] cw;
    logic [3:0] nib;
    logic [2:0] syn;
    int         lat;
    logic [1:0] exp_state;
    logic       exp_bv;
    logic [7:0] exp_byte;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one codeword; optionally answer it 'lat' cycles after dec_ena.
  // Returns on the falling edge after the response (or in ISSUE if silent).
  task automatic send_cw(input logic [6:0] cw, input logic [3:0] nib,
                         input logic [2:0] syn, input int lat,
                         input bit respond, input bit clr_at_dv);
    @(negedge clk);
    bus.uart_valid = 1'b1;
    bus.uart_data  = cw;
    @(negedge clk);
    bus.uart_valid = 1'b0;
    check("dec_ena_issue", bus.dec_ena, 1);
    check("dec_in_latched", bus.dec_in, cw);
    if (respond) begin
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        if (i == 1) check("dec_ena_one_cycle", bus.dec_ena, 0);
      end
      bus.dec_valid    = 1'b1;
      bus.dec_data     = nib;
      bus.dec_syndrome = syn;
      bus.clr_flags    = clr_at_dv;
      @(negedge clk);
      bus.dec_valid    = 1'b0;
      bus.dec_syndrome = 3'd0;
      bus.clr_flags    = 1'b0;
    end
  endtask

  // Two clean nibbles with byte_ready high: byte visible for one cycle.
  task automatic send_pair(input logic [3:0] lo, input logic [3:0] hi,
                           input logic [7:0] exp, input string tag);
    send_cw(7'h11, lo, 3'd0, 2, 1'b1, 1'b0);
    check({tag, "_state_after_lo"}, bus.state_dbg, 0);
    send_cw(7'h22, hi, 3'd0, 2, 1'b1, 1'b0);
    check({tag, "_byte_valid"}, bus.byte_valid, 1);
    check({tag, "_byte_data"}, bus.byte_data, exp);
    check({tag, "_state_out"}, bus.state_dbg, 3);
    @(negedge clk);
    check({tag, "_state_idle"}, bus.state_dbg, 0);
    check({tag, "_valid_cleared"}, bus.byte_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},     bus.state_dbg,  0);
    check({tag, "_dec_ena"},   bus.dec_ena,    0);
    check({tag, "_dec_in"},    bus.dec_in,     0);
    check({tag, "_byte_data"}, bus.byte_data,  0);
    check({tag, "_byte_vld"},  bus.byte_valid, 0);
    check({tag, "_err_cnt"},   bus.err_count,  0);
    check({tag, "_overrun"},   bus.overrun,    0);
    check({tag, "_timeout"},   bus.timeout,    0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ena_seen;
    bit   unstable;
    int   waited;

    rst              = 1'b1;
    bus.uart_valid   = 1'b0;
    bus.uart_data    = '0;
    bus.dec_valid    = 1'b0;
    bus.dec_data     = '0;
    bus.dec_syndrome = '0;
    bus.byte_ready   = 1'b0;
    bus.clr_flags    = 1'b0;

    // {cw, nibble, syndrome, latency, exp state, exp valid, exp byte, exp err}
    vecs[0] = '{7'h55, 4'h3, 3'd0, 2, 2'd0, 1'b0, 8'h00, 0};
    vecs[1] = '{7'h2A, 4'hC, 3'd0, 2, 2'd3, 1'b1, 8'hC3, 0};
    vecs[2] = '{7'h11, 4'h5, 3'd5, 2, 2'd0, 1'b0, 8'h00, 1};
    vecs[3] = '{7'h22, 4'h6, 3'd0, 3, 2'd3, 1'b1, 8'h65, 1};
    vecs[4] = '{7'h33, 4'h7, 3'd3, 1, 2'd0, 1'b0, 8'h00, 2};
    vecs[5] = '{7'h44, 4'h8, 3'd0, 4, 2'd3, 1'b1, 8'h87, 2};

    @(negedge clk);
    check_reset_vals("por");
    rst            = 1'b0;
    bus.byte_ready = 1'b1;

    // Normal pairs and corrected-error counting.
    for (int v = 0; v < 6; v++) begin
      send_cw(vecs[v].cw, vecs[v].nib, vecs[v].syn, vecs[v].lat, 1'b1, 1'b0);
      check($sformatf("vec%0d_state", v), bus.state_dbg, vecs[v].exp_state);
      check($sformatf("vec%0d_byte_valid", v), bus.byte_valid, vecs[v].exp_bv);
      check($sformatf("vec%0d_err_count", v), bus.err_count, vecs[v].exp_err);
      if (vecs[v].exp_bv) begin
        check($sformatf("vec%0d_byte_data", v), bus.byte_data, vecs[v].exp_byte);
        @(negedge clk);
        check($sformatf("vec%0d_back_idle", v), bus.state_dbg, 0);
      end
    end

    // Backpressure with a codeword dropped during OUT.
    check("bp_overrun_before", bus.overrun, 0);
    bus.byte_ready = 1'b0;
    send_cw(7'h55, 4'h3, 3'd0, 2, 1'b1, 1'b0);
    send_cw(7'h2A, 4'hC, 3'd0, 2, 1'b1, 1'b0);
    ena_seen = 1'b0;
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.uart_valid = (i == 3);
      bus.uart_data  = 7'h7F;
      @(negedge clk);
      if (bus.dec_ena) ena_seen = 1'b1;
      if (bus.byte_data !== 8'hC3 || bus.byte_valid !== 1'b1) unstable = 1'b1;
    end
    bus.uart_valid = 1'b0;
    check("bp_byte_stable", unstable, 0);
    check("bp_no_dec_ena", ena_seen, 0);
    check("bp_overrun_set", bus.overrun, 1);
    check("bp_dec_in_kept", bus.dec_in, 7'h2A);
    check("bp_state_out", bus.state_dbg, 3);
    bus.byte_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_idle", bus.state_dbg, 0);
    check("bp_accept_valid", bus.byte_valid, 0);
    send_pair(4'h9, 4'h4, 8'h49, "bp_next");

    pulse_clr();
    check("clr_err", bus.err_count, 0);
    check("clr_overrun", bus.overrun, 0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send_cw(7'h40, 4'(i), 3'd1, 1, 1'b1, 1'b0);
      @(negedge clk);
    end
    check("sat_err_count", bus.err_count, 255);
    pulse_clr();
    check("sat_clr", bus.err_count, 0);

    // Clear coinciding with a corrected-error increment.
    send_cw(7'h41, 4'h1, 3'd6, 2, 1'b1, 1'b1);
    check("clr_wins_err", bus.err_count, 0);
    send_cw(7'h42, 4'h2, 3'd0, 2, 1'b1, 1'b0);
    @(negedge clk);

    // Timeout: second codeword is never answered.
    send_cw(7'h03, 4'h7, 3'd0, 2, 1'b1, 1'b0);
    send_cw(7'h04, 4'h0, 3'd0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("to_in_wait", bus.state_dbg, 2);
    waited = 0;
    while (!bus.timeout && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("to_latency", waited, TO);
    check("to_flag", bus.timeout, 1);
    check("to_back_idle", bus.state_dbg, 0);
    send_pair(4'h1, 4'h2, 8'h21, "to_stale_dropped");
    pulse_clr();
    check("to_clr", bus.timeout, 0);

    // Response in the very last allowed wait cycle.
    send_cw(7'h05, 4'hA, 3'd0, TO, 1'b1, 1'b0);
    check("edge_no_timeout", bus.timeout, 0);
    check("edge_state_idle", bus.state_dbg, 0);
    send_cw(7'h06, 4'hB, 3'd0, 2, 1'b1, 1'b0);
    check("edge_byte_valid", bus.byte_valid, 1);
    check("edge_byte_data", bus.byte_data, 8'hBA);
    @(negedge clk);

    // dec_valid while IDLE is ignored.
    bus.dec_valid    = 1'b1;
    bus.dec_data     = 4'hF;
    bus.dec_syndrome = 3'd7;
    @(negedge clk);
    bus.dec_valid    = 1'b0;
    bus.dec_syndrome = 3'd0;
    @(negedge clk);
    check("idle_dv_err", bus.err_count, 0);
    check("idle_dv_state", bus.state_dbg, 0);
    send_pair(4'h3, 4'h4, 8'h43, "idle_dv_nibble");

    // Reset while waiting for the second nibble.
    send_cw(7'h01, 4'h9, 3'd1, 2, 1'b1, 1'b0);
    check("rst1_err_before", bus.err_count, 1);
    send_cw(7'h02, 4'h0, 3'd0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst1_in_wait", bus.state_dbg, 2);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    send_pair(4'h5, 4'h6, 8'h65, "rst1_fresh");

    // Reset while a byte is being offered.
    bus.byte_ready = 1'b0;
    send_cw(7'h07, 4'h1, 3'd0, 2, 1'b1, 1'b0);
    send_cw(7'h08, 4'h2, 3'd0, 2, 1'b1, 1'b0);
    check("rst2_valid_before", bus.byte_valid, 1);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_out");
    @(negedge clk);
    rst = 1'b0;
    bus.byte_ready = 1'b1;
    send_pair(4'hD, 4'hE, 8'hED, "rst2_fresh");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_rx_sequencer.md
Name: hamming_rx_sequencer

Overview:
Controller between the UART receiver and the Hamming(7,4) decoder. Captures each received 7-bit codeword and issues a one-cycle decoder enable. It then waits for the decoder result with a timeout, packs two decoded nibbles into one byte (low nibble first) and presents the byte on a valid/ready handshake. It also keeps a saturating corrected-error count and sticky overrun/timeout flags for status readout.

Parameters:
TIMEOUT_CYCLES, 15, max cycles spent in WAIT for dec_valid before abort (range 1..255)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
uart_valid  in  1  one-cycle pulse: uart_data holds a new codeword
uart_data  in  7  received Hamming codeword
dec_ena  out  1  one-cycle enable to the decoder
dec_in  out  7  latched codeword driven to the decoder
dec_valid  in  1  decoder result valid pulse
dec_data  in  4  decoded nibble
dec_syndrome  in  3  decoder syndrome; nonzero means a corrected error
byte_data  out  8  assembled byte {second nibble, first nibble}
byte_valid  out  1  byte available
byte_ready  in  1  consumer accepts byte
clr_flags  in  1  clears overrun, timeout and err_count
err_count  out  ERR_CNT_W  saturating count of nonzero syndromes
overrun  out  1  sticky: codeword dropped while busy
timeout  out  1  sticky: decoder failed to respond in time
state_dbg  out  2  current FSM state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state IDLE, dec_ena 0, dec_in 0, byte_data 0, byte_valid 0, nibble index 0, err_count 0, overrun 0, timeout 0, timer 0.
- FSM states and encodings: IDLE=0, ISSUE=1, WAIT=2, OUT=3.
- IDLE:
  - On uart_valid, latch uart_data into dec_in and go to ISSUE.
- ISSUE:
  - dec_ena=1 for exactly this cycle. Clear the timer. Go to WAIT.
  - uart_valid at cycle T gives dec_ena high at T+1.
- WAIT:
  - The timer increments each cycle.
  - If dec_valid arrives, store dec_data:
    - Nibble index 0: store as the low nibble, set index to 1, go to IDLE.
    - Nibble index 1: byte_data <= {dec_data, low}, byte_valid <= 1, index <= 0, go to OUT. byte_valid rises the cycle after dec_valid.
  - If dec_valid arrives with dec_syndrome != 0, err_count increments, saturating at all-ones.
  - If the timer reaches TIMEOUT_CYCLES without dec_valid:
    - set timeout;
    - discard any stored low nibble (index <= 0);
    - go to IDLE.
  - dec_valid in the same cycle the timer expires counts as a response; no timeout is raised.
- OUT:
  - byte_valid held high; byte_data stable until accepted.
  - When byte_ready=1 while byte_valid=1: clear byte_valid, go to IDLE.
  - The transfer completes in the same cycle; a new uart_valid is accepted no earlier than the next cycle in IDLE.
- Overrun: uart_valid in any state other than IDLE sets overrun and the codeword is dropped. dec_in is not modified.
- dec_valid outside WAIT is ignored; it does not change nibble or err_count.
- clr_flags:
  - Synchronously clears overrun, timeout and err_count.
  - If it coincides with a set or increment event, the clear wins.
  - It does not affect the FSM, the stored nibble or the byte.
- Reset mid-operation aborts everything immediately:
  - the stored nibble is lost;
  - byte_valid drops asynchronously.

Decomposition:
- Package hamming_rx_pkg holds:
  - state enum with fixed 2-bit encodings;
  - DEFAULT_TIMEOUT=15;
  - codeword width 7 and nibble width 4 constants.
- One sub-module: rx_timeout_timer. Inputs: clear, enable and limit. Output: an expired pulse. It isolates the WAIT timer.

Test Plan:
1. Normal pair. uart_valid with cw 0x55; the decoder model returns nibble 0x3 with syndrome 0, 2 cycles after dec_ena. Then cw 0x2A returns nibble 0xC. Expect:
   - dec_ena one cycle high, the cycle after each uart_valid;
   - byte_data=0xC3 with byte_valid=1;
   - with byte_ready held 1, byte accepted and FSM back in IDLE (state_dbg=0).
2. Backpressure. Hold byte_ready=0 for 10 cycles after byte_valid; pulse uart_valid during OUT. Expect:
   - byte_data stable at 0xC3;
   - overrun=1;
   - dec_ena not pulsed;
   - assert byte_ready: byte accepted, next codeword processed normally.
3. Corrected errors. Four nibbles returned with syndromes 5, 0, 3, 0. Expect err_count=2, bytes delivered normally. Force 300 errors with ERR_CNT_W=8: err_count saturates at 255. Pulse clr_flags: err_count=0.
4. Timeout. First nibble decoded; second codeword is never answered by the decoder model. Expect:
   - timeout=1 exactly TIMEOUT_CYCLES cycles after entering WAIT;
   - FSM back in IDLE;
   - next two nibbles 0x1 then 0x2 give byte 0x21, with the stale nibble discarded.
5. Edge: dec_valid in the same cycle the timer reaches its limit. Expect no timeout and the nibble stored. dec_valid injected while in IDLE: ignored, no err_count change.
6. Reset mid-operation. Assert rst asynchronously while in WAIT with index=1, and again with byte_valid=1. Expect all outputs at reset values immediately. After release, a fresh two-codeword sequence gives a correct byte.
